// File: rtl/blackparrot_fpga_host_axil_write_arbiter.sv
// rtl/blackparrot_fpga_host_axil_write_arbiter.sv - round-robin 2:1 AXI-Lite write arbiter
// Grants one complete AW+W+B write at a time and returns B only to the grantee.
module blackparrot_fpga_host_axil_write_arbiter #(
  parameter int S_AXIL_ADDR_WIDTH = 64,
  parameter int S_AXIL_DATA_WIDTH = 32
) (
  input  logic                           s_axil_aclk,
  input  logic                           s_axil_areset,

  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s0_axil_awaddr,
  input  logic [2:0]                     s0_axil_awprot,
  input  logic                           s0_axil_awvalid,
  output logic                           s0_axil_awready,
  input  logic [S_AXIL_DATA_WIDTH-1:0]   s0_axil_wdata,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0] s0_axil_wstrb,
  input  logic                           s0_axil_wvalid,
  output logic                           s0_axil_wready,
  output logic [1:0]                     s0_axil_bresp,
  output logic                           s0_axil_bvalid,
  input  logic                           s0_axil_bready,

  input  logic [S_AXIL_ADDR_WIDTH-1:0]   s1_axil_awaddr,
  input  logic [2:0]                     s1_axil_awprot,
  input  logic                           s1_axil_awvalid,
  output logic                           s1_axil_awready,
  input  logic [S_AXIL_DATA_WIDTH-1:0]   s1_axil_wdata,
  input  logic [S_AXIL_DATA_WIDTH/8-1:0] s1_axil_wstrb,
  input  logic                           s1_axil_wvalid,
  output logic                           s1_axil_wready,
  output logic [1:0]                     s1_axil_bresp,
  output logic                           s1_axil_bvalid,
  input  logic                           s1_axil_bready,

  output logic [S_AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [S_AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [S_AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready,

  output logic                           grant_o,
  output logic                           busy_o
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_gnt_q, last_gnt_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic   sg_awvalid, sg_wvalid, sg_bready;
  logic   aw_hs, w_hs;

  assign sg_awvalid = gnt_q ? s1_axil_awvalid : s0_axil_awvalid;
  assign sg_wvalid  = gnt_q ? s1_axil_wvalid  : s0_axil_wvalid;
  assign sg_bready  = gnt_q ? s1_axil_bready  : s0_axil_bready;

  // Payload muxes follow gnt in every state; only the valids are gated.
  assign m_axil_awaddr = gnt_q ? s1_axil_awaddr : s0_axil_awaddr;
  assign m_axil_awprot = gnt_q ? s1_axil_awprot : s0_axil_awprot;
  assign m_axil_wdata  = gnt_q ? s1_axil_wdata  : s0_axil_wdata;
  assign m_axil_wstrb  = gnt_q ? s1_axil_wstrb  : s0_axil_wstrb;

  assign aw_hs = (state_q == XFER) & sg_awvalid & m_axil_awready & ~aw_done_q;
  assign w_hs  = (state_q == XFER) & sg_wvalid  & m_axil_wready  & ~w_done_q;

  assign grant_o = gnt_q;
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge s_axil_aclk or posedge s_axil_areset) begin
    if (s_axil_areset) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      IDLE: begin
        // A tie goes to whoever did not win last time.
        if (s0_axil_awvalid | s1_axil_awvalid) begin
          gnt_d      = (s0_axil_awvalid & s1_axil_awvalid) ? ~last_gnt_q : s1_axil_awvalid;
          last_gnt_d = gnt_d;
          state_d    = XFER;
        end
      end
      XFER: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d & w_done_d) state_d = RESP;
      end
      RESP: begin
        if (m_axil_bvalid & sg_bready) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axil_awvalid  = 1'b0;
    m_axil_wvalid   = 1'b0;
    m_axil_bready   = 1'b0;
    s0_axil_awready = 1'b0;
    s0_axil_wready  = 1'b0;
    s0_axil_bvalid  = 1'b0;
    s0_axil_bresp   = 2'b00;
    s1_axil_awready = 1'b0;
    s1_axil_wready  = 1'b0;
    s1_axil_bvalid  = 1'b0;
    s1_axil_bresp   = 2'b00;
    case (state_q)
      XFER: begin
        m_axil_awvalid = sg_awvalid & ~aw_done_q;
        m_axil_wvalid  = sg_wvalid & ~w_done_q;
        if (gnt_q) begin
          s1_axil_awready = m_axil_awready & ~aw_done_q;
          s1_axil_wready  = m_axil_wready & ~w_done_q;
        end else begin
          s0_axil_awready = m_axil_awready & ~aw_done_q;
          s0_axil_wready  = m_axil_wready & ~w_done_q;
        end
      end
      RESP: begin
        m_axil_bready = sg_bready;
        if (gnt_q) begin
          s1_axil_bvalid = m_axil_bvalid;
          s1_axil_bresp  = m_axil_bresp;
        end else begin
          s0_axil_bvalid = m_axil_bvalid;
          s0_axil_bresp  = m_axil_bresp;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_blackparrot_fpga_host_axil_write_arbiter.sv
// tb/tb_blackparrot_fpga_host_axil_write_arbiter.sv - directed bench for the AXI-Lite write arbiter
module tb_blackparrot_fpga_host_axil_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [63:0] s0_awaddr = '0, s1_awaddr = '0;
  logic [2:0]  s0_awprot = '0, s1_awprot = '0;
  logic        s0_awvalid = 0, s1_awvalid = 0;
  logic        s0_awready, s1_awready;
  logic [31:0] s0_wdata = '0, s1_wdata = '0;
  logic [3:0]  s0_wstrb = '0, s1_wstrb = '0;
  logic        s0_wvalid = 0, s1_wvalid = 0;
  logic        s0_wready, s1_wready;
  logic [1:0]  s0_bresp, s1_bresp;
  logic        s0_bvalid, s1_bvalid;
  logic        s0_bready = 0, s1_bready = 0;

  logic [63:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_awvalid;
  logic        m_awready = 0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 0;
  logic        m_bready;
  logic        grant_o, busy_o;

  int checks = 0;
  int errors = 0;

  logic [10:0] ctl;
  logic [5:0]  s1_ctl;
  assign ctl    = {m_awvalid, m_wvalid, m_bready, s0_awready, s0_wready, s0_bvalid,
                   s1_awready, s1_wready, s1_bvalid, busy_o, grant_o};
  assign s1_ctl = {s1_awready, s1_wready, s1_bvalid, s1_bresp, 1'b0};

  always #5 clk = ~clk;

  blackparrot_fpga_host_axil_write_arbiter #(
    .S_AXIL_ADDR_WIDTH(64),
    .S_AXIL_DATA_WIDTH(32)
  ) dut (
    .s_axil_aclk(clk), .s_axil_areset(rst),
    .s0_axil_awaddr(s0_awaddr), .s0_axil_awprot(s0_awprot), .s0_axil_awvalid(s0_awvalid),
    .s0_axil_awready(s0_awready), .s0_axil_wdata(s0_wdata), .s0_axil_wstrb(s0_wstrb),
    .s0_axil_wvalid(s0_wvalid), .s0_axil_wready(s0_wready), .s0_axil_bresp(s0_bresp),
    .s0_axil_bvalid(s0_bvalid), .s0_axil_bready(s0_bready),
    .s1_axil_awaddr(s1_awaddr), .s1_axil_awprot(s1_awprot), .s1_axil_awvalid(s1_awvalid),
    .s1_axil_awready(s1_awready), .s1_axil_wdata(s1_wdata), .s1_axil_wstrb(s1_wstrb),
    .s1_axil_wvalid(s1_wvalid), .s1_axil_wready(s1_wready), .s1_axil_bresp(s1_bresp),
    .s1_axil_bvalid(s1_bvalid), .s1_axil_bready(s1_bready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
    .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
    .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_awvalid = 0; s0_wvalid = 0; s0_bready = 0;
    s1_awvalid = 0; s1_wvalid = 0; s1_bready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (ctl !== 11'd0) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 11'd0); end
    checks++; if ({s0_bresp, s1_bresp} !== 4'd0) begin errors++; $display("FAIL reset_bresp got %b exp 0000", {s0_bresp, s1_bresp}); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_write();
    s0_awaddr = 64'h4; s0_awprot = 3'b010; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
    s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1;
    #1;
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL single_idle_awvalid got %b exp 0", m_awvalid); end
    tick();
    checks++; if ({m_awvalid, m_wvalid} !== 2'b11) begin errors++; $display("FAIL single_valids got %b exp 11", {m_awvalid, m_wvalid}); end
    checks++; if (m_awaddr !== 64'h4) begin errors++; $display("FAIL single_awaddr got %h exp 4", m_awaddr); end
    checks++; if (m_awprot !== 3'b010) begin errors++; $display("FAIL single_awprot got %b exp 010", m_awprot); end
    checks++; if ({m_wdata, m_wstrb} !== {32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL single_wdata got %h %h exp deadbeef f", m_wdata, m_wstrb); end
    checks++; if ({busy_o, grant_o} !== 2'b10) begin errors++; $display("FAIL single_busy_grant got %b exp 10", {busy_o, grant_o}); end
    m_awready = 1; m_wready = 1;
    #1;
    checks++; if ({s0_awready, s0_wready} !== 2'b11) begin errors++; $display("FAIL single_readies got %b exp 11", {s0_awready, s0_wready}); end
    checks++; if (s1_ctl !== 6'd0) begin errors++; $display("FAIL single_s1_xfer got %b exp 0", s1_ctl); end
    tick();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = 2'b00;
    #1;
    checks++; if ({s0_bvalid, s0_bresp, m_bready} !== 4'b1001) begin errors++; $display("FAIL single_b got %b exp 1001", {s0_bvalid, s0_bresp, m_bready}); end
    checks++; if (s1_ctl !== 6'd0) begin errors++; $display("FAIL single_s1_resp got %b exp 0", s1_ctl); end
    tick();
    m_bvalid = 0;
    #1;
    checks++; if ({busy_o, s0_bvalid} !== 2'b00) begin errors++; $display("FAIL single_done got %b exp 00", {busy_o, s0_bvalid}); end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    for (int rep = 0; rep < 2; rep++) begin
      s0_awaddr = 64'h0; s1_awaddr = 64'h4;
      s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1;
      s1_awvalid = 1; s1_wvalid = 1; s1_bready = 1;
      m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 2'b00;
      tick();
      checks++; if ({grant_o, s0_awready, s1_awready} !== 3'b010) begin errors++; $display("FAIL sim%0d_first got %b exp 010", rep, {grant_o, s0_awready, s1_awready}); end
      checks++; if (m_awaddr !== 64'h0) begin errors++; $display("FAIL sim%0d_addr0 got %h exp 0", rep, m_awaddr); end
      tick();
      s0_awvalid = 0; s0_wvalid = 0;
      #1;
      checks++; if ({s0_bvalid, s1_bvalid} !== 2'b10) begin errors++; $display("FAIL sim%0d_b0 got %b exp 10", rep, {s0_bvalid, s1_bvalid}); end
      tick();
      checks++; if ({busy_o, grant_o} !== 2'b00) begin errors++; $display("FAIL sim%0d_idle got %b exp 00", rep, {busy_o, grant_o}); end
      tick();
      checks++; if ({grant_o, s0_awready, s1_awready} !== 3'b101) begin errors++; $display("FAIL sim%0d_second got %b exp 101", rep, {grant_o, s0_awready, s1_awready}); end
      checks++; if (m_awaddr !== 64'h4) begin errors++; $display("FAIL sim%0d_addr1 got %h exp 4", rep, m_awaddr); end
      tick();
      s1_awvalid = 0; s1_wvalid = 0;
      #1;
      checks++; if ({s0_bvalid, s1_bvalid} !== 2'b01) begin errors++; $display("FAIL sim%0d_b1 got %b exp 01", rep, {s0_bvalid, s1_bvalid}); end
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL sim%0d_end got %b exp 0", rep, busy_o); end
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_early_w();
    s1_wdata = 32'hCAFE0001; s1_wstrb = 4'h3; s1_awaddr = 64'h8;
    s1_wvalid = 1; m_wready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({busy_o, m_wvalid, s1_wready} !== 3'b000) begin errors++; $display("FAIL early_w_wait%0d got %b exp 000", i, {busy_o, m_wvalid, s1_wready}); end
    end
    s1_awvalid = 1; s1_bready = 1;
    #1;
    checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL early_w_req got %b exp 0", m_wvalid); end
    tick();
    checks++; if ({grant_o, m_awvalid, m_wvalid, s1_wready} !== 4'b1111) begin errors++; $display("FAIL early_w_xfer got %b exp 1111", {grant_o, m_awvalid, m_wvalid, s1_wready}); end
    checks++; if (m_wdata !== 32'hCAFE0001) begin errors++; $display("FAIL early_w_data got %h exp cafe0001", m_wdata); end
    m_awready = 1;
    tick();
    s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 1;
    #1;
    checks++; if ({s1_bvalid, m_bready} !== 2'b11) begin errors++; $display("FAIL early_w_resp got %b exp 11", {s1_bvalid, m_bready}); end
    tick();
    clear_inputs();
    #1;
  endtask

  task automatic test_split();
    int beats;
    beats = 0;
    s0_awaddr = 64'h10; s0_wdata = 32'h00001234; s0_wstrb = 4'h3;
    s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1;
    m_wready = 1; m_awready = 0;
    tick();
    if (m_wvalid && m_wready) beats++;
    checks++; if ({grant_o, m_wvalid, m_awvalid} !== 3'b011) begin errors++; $display("FAIL split_first got %b exp 011", {grant_o, m_wvalid, m_awvalid}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_wvalid && m_wready) beats++;
      checks++; if ({m_wvalid, m_awvalid, busy_o, m_bready} !== 4'b0110) begin errors++; $display("FAIL split_stall%0d got %b exp 0110", i, {m_wvalid, m_awvalid, busy_o, m_bready}); end
    end
    tick();
    m_awready = 1;
    #1;
    if (m_wvalid && m_wready) beats++;
    checks++; if ({s0_awready, s0_wready, m_wvalid, m_bready} !== 4'b1000) begin errors++; $display("FAIL split_aw got %b exp 1000", {s0_awready, s0_wready, m_wvalid, m_bready}); end
    tick();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    #1;
    checks++; if (m_bready !== 1'b1) begin errors++; $display("FAIL split_resp got %b exp 1", m_bready); end
    checks++; if (beats !== 1) begin errors++; $display("FAIL split_beats got %0d exp 1", beats); end
    m_bvalid = 1;
    tick();
    m_bvalid = 0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL split_end got %b exp 0", busy_o); end
    clear_inputs();
  endtask

  task automatic test_error_resp();
    s0_awaddr = 64'h20; s0_awvalid = 1; s0_wvalid = 1; s0_bready = 0;
    m_awready = 1; m_wready = 1;
    tick();
    tick();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) s0_bready = 1;
      #1;
      checks++; if ({s0_bvalid, s0_bresp, busy_o} !== 4'b1101) begin errors++; $display("FAIL err_hold%0d got %b exp 1101", i, {s0_bvalid, s0_bresp, busy_o}); end
      checks++; if (m_bready !== s0_bready) begin errors++; $display("FAIL err_bready%0d got %b exp %b", i, m_bready, s0_bready); end
      tick();
    end
    m_bvalid = 0;
    #1;
    checks++; if ({busy_o, s0_bvalid} !== 2'b00) begin errors++; $display("FAIL err_end got %b exp 00", {busy_o, s0_bvalid}); end
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    s0_awaddr = 64'h30; s0_awvalid = 1; s0_wvalid = 1; s0_bready = 1;
    m_awready = 1; m_wready = 1;
    tick();
    tick();
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b11;
    s0_bready = 0;
    #1;
    checks++; if ({s0_bvalid, busy_o} !== 2'b11) begin errors++; $display("FAIL rr_inresp got %b exp 11", {s0_bvalid, busy_o}); end
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 11'd0) begin errors++; $display("FAIL rr_async got %b exp %b", ctl, 11'd0); end
    checks++; if (s0_bresp !== 2'b00) begin errors++; $display("FAIL rr_bresp got %b exp 00", s0_bresp); end
    clear_inputs();
    tick();
    rst = 1'b0;
    s0_awvalid = 1; s1_awvalid = 1; s0_wvalid = 1; s1_wvalid = 1;
    tick();
    checks++; if ({busy_o, grant_o, s0_awready, s1_awready} !== 4'b1000) begin errors++; $display("FAIL rr_tie got %b exp 1000", {busy_o, grant_o, s0_awready, s1_awready}); end
    clear_inputs();
    pulse_reset();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_simultaneous();
    test_early_w();
    test_split();
    test_error_resp();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
